alu_rs_age_ordered: RTL and testbench

//  Parametrised reservation station for the ALU (and any other single-issue FU).

---
 rtl/alu_rs_age_ordered.sv | 200 ++++++++++++++++++++
 tb/tb_alu_rs_age_ordered.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_age_ordered.sv
// Age-ordered reservation station for a single-issue unit: snoops NCDB result buses,
// wakes pending operands and issues the oldest ready op through a valid/ready register.
module alu_rs_age_ordered #(
    parameter int DEPTH    = 8,
    parameter int NCDB     = 2,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int TAG_FREE = 0,
    parameter int NAME_W   = 5,
    parameter int OP_W     = 6,
    parameter int IMM_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NCDB-1:0]          cdb_valid,
    input  logic [NCDB*TAG_W-1:0]    cdb_tag,
    input  logic [NCDB*DATA_W-1:0]   cdb_data,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [OP_W-1:0]          alloc_op,
    input  logic [IMM_W-1:0]         alloc_imm,
    input  logic [NAME_W-1:0]        alloc_name_w,
    input  logic [TAG_W-1:0]         alloc_tag_w,
    input  logic [DATA_W-1:0]        alloc_data_o,
    input  logic [DATA_W-1:0]        alloc_data_t,
    input  logic [TAG_W-1:0]         alloc_tag_o,
    input  logic [TAG_W-1:0]         alloc_tag_t,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [OP_W-1:0]          issue_op,
    output logic [IMM_W-1:0]         issue_imm,
    output logic [NAME_W-1:0]        issue_name_w,
    output logic [TAG_W-1:0]         issue_tag_w,
    output logic [DATA_W-1:0]        issue_data_o,
    output logic [DATA_W-1:0]        issue_data_t,
    output logic [$clog2(DEPTH):0]   free_count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [TAG_W-1:0] FREE = TAG_W'(TAG_FREE);

    // Returns {tag, data} after this-cycle CDB match; lowest port index wins.
    function automatic logic [TAG_W+DATA_W-1:0] snoop(
        input logic [TAG_W-1:0]        tag,
        input logic [DATA_W-1:0]       data,
        input logic [NCDB-1:0]         v,
        input logic [NCDB*TAG_W-1:0]   tags,
        input logic [NCDB*DATA_W-1:0]  datas
    );
        logic [TAG_W+DATA_W-1:0] r;
        r = {tag, data};
        for (int p = NCDB - 1; p >= 0; p--) begin
            if (v[p] && (tag != FREE) && (tag == tags[p*TAG_W +: TAG_W]))
                r = {FREE, datas[p*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    logic [DEPTH-1:0]  valid_reg;
    logic [IDX_W-1:0]  rank_reg   [DEPTH];
    logic [OP_W-1:0]   op_reg     [DEPTH];
    logic [IMM_W-1:0]  imm_reg    [DEPTH];
    logic [NAME_W-1:0] name_reg   [DEPTH];
    logic [TAG_W-1:0]  tagw_reg   [DEPTH];
    logic [TAG_W-1:0]  tag_o_reg  [DEPTH];
    logic [TAG_W-1:0]  tag_t_reg  [DEPTH];
    logic [DATA_W-1:0] data_o_reg [DEPTH];
    logic [DATA_W-1:0] data_t_reg [DEPTH];

    logic [TAG_W-1:0]  wake_tag_o  [DEPTH];
    logic [TAG_W-1:0]  wake_tag_t  [DEPTH];
    logic [DATA_W-1:0] wake_data_o [DEPTH];
    logic [DATA_W-1:0] wake_data_t [DEPTH];
    logic [DEPTH-1:0]  ready;

    logic [TAG_W-1:0]  new_tag_o, new_tag_t;
    logic [DATA_W-1:0] new_data_o, new_data_t;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wake
            assign {wake_tag_o[gi], wake_data_o[gi]} =
                snoop(tag_o_reg[gi], data_o_reg[gi], cdb_valid, cdb_tag, cdb_data);
            assign {wake_tag_t[gi], wake_data_t[gi]} =
                snoop(tag_t_reg[gi], data_t_reg[gi], cdb_valid, cdb_tag, cdb_data);
            assign ready[gi] = valid_reg[gi] && (wake_tag_o[gi] == FREE) && (wake_tag_t[gi] == FREE);
        end
    endgenerate

    assign {new_tag_o, new_data_o} = snoop(alloc_tag_o, alloc_data_o, cdb_valid, cdb_tag, cdb_data);
    assign {new_tag_t, new_data_t} = snoop(alloc_tag_t, alloc_data_t, cdb_valid, cdb_tag, cdb_data);

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx, sel_rank, free_idx, new_rank;
    logic [CNT_W-1:0] valid_cnt;
    logic             can_load, do_issue, do_alloc;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_rank  = '0;
        free_idx  = '0;
        valid_cnt = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_reg[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            valid_cnt = valid_cnt + CNT_W'(valid_reg[i]);
            if (ready[i] && (!sel_found || rank_reg[i] < sel_rank)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_rank  = rank_reg[i];
            end
        end
    end

    assign free_count  = CNT_W'(DEPTH) - valid_cnt;
    assign alloc_ready = (free_count != '0);
    assign can_load    = !issue_valid || issue_ready;
    assign do_issue    = can_load && sel_found;
    assign do_alloc    = alloc_valid && alloc_ready;
    // Youngest rank is the occupancy left after this cycle's removal.
    assign new_rank    = IDX_W'(valid_cnt - CNT_W'(do_issue));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_reg[i]  <= 1'b0;
                rank_reg[i]   <= '0;
                op_reg[i]     <= '0;
                imm_reg[i]    <= '0;
                name_reg[i]   <= '0;
                tagw_reg[i]   <= FREE;
                tag_o_reg[i]  <= FREE;
                tag_t_reg[i]  <= FREE;
                data_o_reg[i] <= '0;
                data_t_reg[i] <= '0;
            end
        end else if (flush) begin
            valid_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_alloc && free_idx == IDX_W'(i)) begin
                    valid_reg[i]  <= 1'b1;
                    rank_reg[i]   <= new_rank;
                    op_reg[i]     <= alloc_op;
                    imm_reg[i]    <= alloc_imm;
                    name_reg[i]   <= alloc_name_w;
                    tagw_reg[i]   <= alloc_tag_w;
                    tag_o_reg[i]  <= new_tag_o;
                    tag_t_reg[i]  <= new_tag_t;
                    data_o_reg[i] <= new_data_o;
                    data_t_reg[i] <= new_data_t;
                end else if (valid_reg[i]) begin
                    if (do_issue && sel_idx == IDX_W'(i)) begin
                        valid_reg[i] <= 1'b0;
                    end else begin
                        tag_o_reg[i]  <= wake_tag_o[i];
                        tag_t_reg[i]  <= wake_tag_t[i];
                        data_o_reg[i] <= wake_data_o[i];
                        data_t_reg[i] <= wake_data_t[i];
                        if (do_issue && rank_reg[i] > sel_rank)
                            rank_reg[i] <= rank_reg[i] - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid  <= 1'b0;
            issue_op     <= '0;
            issue_imm    <= '0;
            issue_name_w <= '0;
            issue_tag_w  <= FREE;
            issue_data_o <= '0;
            issue_data_t <= '0;
        end else if (flush) begin
            issue_valid  <= 1'b0;
            issue_op     <= '0;
            issue_imm    <= '0;
            issue_name_w <= '0;
            issue_tag_w  <= FREE;
            issue_data_o <= '0;
            issue_data_t <= '0;
        end else if (can_load) begin
            issue_valid <= sel_found;
            if (sel_found) begin
                issue_op     <= op_reg[sel_idx];
                issue_imm    <= imm_reg[sel_idx];
                issue_name_w <= name_reg[sel_idx];
                issue_tag_w  <= tagw_reg[sel_idx];
                issue_data_o <= wake_data_o[sel_idx];
                issue_data_t <= wake_data_t[sel_idx];
            end
        end
    end
endmodule

// File: tb/tb_alu_rs_age_ordered.sv
// Bench for alu_rs_age_ordered: directed scenarios plus random traffic, all checked
// against an age-ordered queue model of the station and its issue register.
module tb_alu_rs_age_ordered;
    localparam int DEPTH = 8;
    localparam int NCDB  = 2;
    localparam int DW    = 32;
    localparam int TW    = 4;

    logic             clk = 1'b0;
    logic             rst, flush;
    logic [NCDB-1:0]  cdb_valid;
    logic [NCDB*TW-1:0] cdb_tag;
    logic [NCDB*DW-1:0] cdb_data;
    logic             alloc_valid, alloc_ready;
    logic [5:0]       alloc_op;
    logic [31:0]      alloc_imm;
    logic [4:0]       alloc_name_w;
    logic [TW-1:0]    alloc_tag_w, alloc_tag_o, alloc_tag_t;
    logic [DW-1:0]    alloc_data_o, alloc_data_t;
    logic             issue_valid, issue_ready;
    logic [5:0]       issue_op;
    logic [31:0]      issue_imm;
    logic [4:0]       issue_name_w;
    logic [TW-1:0]    issue_tag_w;
    logic [DW-1:0]    issue_data_o, issue_data_t;
    logic [3:0]       free_count;

    alu_rs_age_ordered dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_op(alloc_op), .alloc_imm(alloc_imm), .alloc_name_w(alloc_name_w),
        .alloc_tag_w(alloc_tag_w), .alloc_data_o(alloc_data_o), .alloc_data_t(alloc_data_t),
        .alloc_tag_o(alloc_tag_o), .alloc_tag_t(alloc_tag_t),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_imm(issue_imm), .issue_name_w(issue_name_w),
        .issue_tag_w(issue_tag_w), .issue_data_o(issue_data_o), .issue_data_t(issue_data_t),
        .free_count(free_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]    op;
        logic [31:0]   imm;
        logic [4:0]    name;
        logic [TW-1:0] tagw;
        logic [TW-1:0] tag_o;
        logic [TW-1:0] tag_t;
        logic [DW-1:0] data_o;
        logic [DW-1:0] data_t;
    } ent_t;

    // Station contents in age order (front = oldest); tag 0 means value present.
    ent_t mq[$];
    bit   m_iv;
    ent_t m_is;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   serial = 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t wake(ent_t e);
        for (int p = 0; p < NCDB; p++) begin
            if (cdb_valid[p] && e.tag_o != 0 && e.tag_o == cdb_tag[p*TW +: TW]) begin
                e.tag_o  = 0;
                e.data_o = cdb_data[p*DW +: DW];
            end
            if (cdb_valid[p] && e.tag_t != 0 && e.tag_t == cdb_tag[p*TW +: TW]) begin
                e.tag_t  = 0;
                e.data_t = cdb_data[p*DW +: DW];
            end
        end
        return e;
    endfunction

    task automatic model_step();
        int   n0, sel;
        ent_t e;
        if (rst || flush) begin
            mq.delete();
            m_iv = 0;
            m_is = '0;
            return;
        end
        n0 = mq.size();
        foreach (mq[i]) mq[i] = wake(mq[i]);
        if (!m_iv || issue_ready) begin
            sel = -1;
            foreach (mq[i]) if (sel < 0 && mq[i].tag_o == 0 && mq[i].tag_t == 0) sel = i;
            if (sel >= 0) begin
                m_is = mq[sel];
                mq.delete(sel);
                m_iv = 1;
            end else begin
                m_iv = 0;
            end
        end
        if (alloc_valid && n0 < DEPTH) begin
            e.op = alloc_op;  e.imm = alloc_imm;  e.name = alloc_name_w;  e.tagw = alloc_tag_w;
            e.tag_o = alloc_tag_o;  e.data_o = alloc_data_o;
            e.tag_t = alloc_tag_t;  e.data_t = alloc_data_t;
            mq.push_back(wake(e));
        end
    endtask

    task automatic check_all();
        chk("free_count", free_count, DEPTH - mq.size());
        chk("alloc_ready", alloc_ready, mq.size() < DEPTH);
        chk("issue_valid", issue_valid, m_iv);
        if (m_iv) begin
            chk("issue_op", issue_op, m_is.op);
            chk("issue_imm", issue_imm, m_is.imm);
            chk("issue_name_w", issue_name_w, m_is.name);
            chk("issue_tag_w", issue_tag_w, m_is.tagw);
            chk("issue_data_o", issue_data_o, m_is.data_o);
            chk("issue_data_t", issue_data_t, m_is.data_t);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_iv && issue_ready && !rst && !flush)
            $display("handoff op=%0d imm=%0h data_o=%0h data_t=%0h", m_is.op, m_is.imm, m_is.data_o, m_is.data_t);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic offer(input logic [TW-1:0] to, input logic [DW-1:0] d_o,
                         input logic [TW-1:0] tt, input logic [DW-1:0] d_t);
        alloc_valid  = 1'b1;
        alloc_op     = 6'(serial);
        alloc_imm    = 32'(serial);
        alloc_name_w = 5'($urandom);
        alloc_tag_w  = 4'($urandom_range(1, 15));
        alloc_tag_o  = to;
        alloc_data_o = d_o;
        alloc_tag_t  = tt;
        alloc_data_t = d_t;
        serial++;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        cdb_valid   = '0;
        flush       = 1'b0;
    endtask

    initial begin
        int first;
        rst = 1'b1;  flush = 1'b0;  issue_ready = 1'b0;
        cdb_valid = '0;  cdb_tag = '0;  cdb_data = '0;
        alloc_valid = 1'b0;  alloc_op = '0;  alloc_imm = '0;  alloc_name_w = '0;
        alloc_tag_w = '0;  alloc_tag_o = '0;  alloc_tag_t = '0;
        alloc_data_o = '0;  alloc_data_t = '0;
        m_iv = 0;  m_is = '0;
        repeat (2) @(negedge clk);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_free_count", free_count, DEPTH);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_issue_op", issue_op, 0);
        chk("rst_issue_tag_w", issue_tag_w, 0);
        chk("rst_issue_data_o", issue_data_o, 0);
        rst = 1'b0;

        // Three ready ops issue in order; first issue two edges after first alloc
        issue_ready = 1'b1;
        first = serial;
        for (int i = 0; i < 3; i++) begin
            offer(0, $urandom, 0, $urandom);
            tick();
            if (i == 0) chk("t1_latency_0", issue_valid, 0);
            if (i == 1) chk("t1_first_imm", issue_imm, first);
        end
        idle();
        repeat (4) tick();

        // Older op waits on tag 5, younger ready op overtakes it
        first = serial;
        offer(5, 0, 0, 32'h11);
        tick();
        offer(0, 32'h22, 0, 32'h33);
        tick();
        idle();
        tick();
        chk("t2_young_first", issue_imm, first + 1);
        cdb_valid = 2'b10;
        cdb_tag   = {4'd5, 4'd0};
        cdb_data  = {32'h1234, 32'h0};
        tick();
        idle();
        chk("t2_old_imm", issue_imm, first);
        chk("t2_old_data_o", issue_data_o, 32'h1234);
        repeat (3) tick();

        // Fill to capacity, free one slot by issuing, then the blocked op gets in
        issue_ready = 1'b0;
        for (int k = 0; k < 20 && alloc_ready; k++) begin
            offer(0, $urandom, 0, $urandom);
            tick();
        end
        chk("t3_full_ready", alloc_ready, 0);
        chk("t3_full_count", free_count, 0);
        offer(0, $urandom, 0, $urandom);
        issue_ready = 1'b1;
        tick();
        chk("t3_slot_freed", alloc_ready, 1);
        issue_ready = 1'b0;
        tick();
        chk("t3_refull", free_count, 0);
        idle();
        issue_ready = 1'b1;
        repeat (12) tick();

        // Backpressure holds the issue register steady
        issue_ready = 1'b0;
        first = serial;
        for (int i = 0; i < 3; i++) begin
            offer(0, $urandom, 0, $urandom);
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_imm", issue_imm, first);
        end
        issue_ready = 1'b1;
        repeat (5) tick();

        // Alloc-cycle bypass from CDB port 0
        offer(0, 32'h5, 7, 0);
        cdb_valid = 2'b01;
        cdb_tag   = {4'd0, 4'd7};
        cdb_data  = {32'h0, 32'hBEEF};
        tick();
        idle();
        tick();
        chk("t5_bypass_valid", issue_valid, 1);
        chk("t5_bypass_data_t", issue_data_t, 32'hBEEF);
        repeat (2) tick();

        // Flush with occupied station and loaded issue register
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(0, $urandom, 0, $urandom);
            tick();
        end
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_flush_valid", issue_valid, 0);
        chk("t6_flush_count", free_count, DEPTH);
        chk("t6_flush_tag_w", issue_tag_w, 0);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) < 6)
                offer($urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)), $urandom,
                      $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15)), $urandom);
            else
                alloc_valid = 1'b0;
            cdb_valid   = 2'($urandom);
            cdb_tag     = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
            cdb_data    = {32'($urandom), 32'($urandom)};
            issue_ready = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 99) == 0);
            tick();
        end
        idle();

        // Asynchronous reset between clock edges takes effect at once
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(0, $urandom, 0, $urandom);
            tick();
        end
        idle();
        #2 rst = 1'b1;
        #1;
        chk("t6_arst_valid", issue_valid, 0);
        chk("t6_arst_count", free_count, DEPTH);
        chk("t6_arst_ready", alloc_ready, 1);
        mq.delete();
        m_iv = 0;
        m_is = '0;
        @(negedge clk);
        rst = 1'b0;
        issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(0, $urandom, 0, $urandom);
            tick();
        end
        idle();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
